bcd_counter_2digit: RTL and testbench
=====================================

# bcd_counter_2digit

Two-digit synchronous BCD up/down counter (00–99) with an internal tick prescaler and a parallel load. It sits directly upstream of the board's 7-segment display decoders: BCD1 and BCD0 each drive one 0–9 display decoder (tens on HEX1, units on HEX0). Digits never leave the range 0–9, so the downstream decoders need no comparator or correction stage. A one-cycle wrap pulse is provided for cascading.

## Interface
- TICK_DIV, default 50000000: clock cycles per count step. With the 50 MHz board clock this gives 1 step/s. Legal range 1 to 2^26.
- Clock  in  1  board clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- En  in  1  count enable; low freezes both the prescaler and the digits.
- Up  in  1  direction: 1 = increment, 0 = decrement.
- Load  in  1  single-cycle parallel load strobe.
- D1  in  4  tens digit to load.
- D0  in  4  units digit to load.
- BCD1  out  4  tens digit, always 0–9, registered.
- BCD0  out  4  units digit, always 0–9, registered.
- Wrap  out  1  one-cycle pulse on 99→00 (up) or 00→99 (down), registered.

## Operation
- Prescaler:
  - 26-bit counter P, counts 0..TICK_DIV-1 while En=1.
  - Internal step strobe S is asserted when P = TICK_DIV-1 and En=1; P returns to 0 on the same edge.
  - P holds its value while En=0.
  - For TICK_DIV=1, S is asserted on every enabled cycle.
- Priority on each edge: Reset > Load > step (S) > hold.
- Reset: P=0, BCD1=0, BCD0=0, Wrap=0.
- Load:
  - Each digit is saturated independently: a value greater than 9 loads as 9.
  - P is cleared to 0 and Wrap=0.
  - Load works regardless of En.
- Step up:
  - BCD0<9: BCD0+1.
  - BCD0=9: BCD0=0 and tens increments. Tens at 9 goes to 0 and Wrap=1.
- Step down:
  - BCD0>0: BCD0-1.
  - BCD0=0: BCD0=9 and tens decrements. Tens at 0 goes to 9 and Wrap=1.
- Wrap is 0 on every cycle without a wrapping step.
- Up is sampled on the step edge only. Changing Up between steps has no other effect.
- Digit arithmetic is per-digit 4-bit with explicit 9/0 boundary tests. Binary overflow into 10–15 is never produced.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Reset:
  - Asserted at edge k: outputs are 0 after edge k.
  - First step after release occurs TICK_DIV enabled cycles after the first cycle with Reset=0 and En=1.
- Load at edge k: the new digits are visible after edge k. The next step is TICK_DIV enabled cycles later.
- Step: S is computed from P before edge k; new digits and Wrap are visible after edge k, so latency is 1 cycle.
- Wrap is high for exactly one cycle per wrap event.
- Load coincident with S: Load wins, no step is taken, and P restarts at 0.
- Reset coincident with Load or S: Reset wins.
- En dropped mid-interval: P freezes, and counting resumes from the frozen P when En returns. Partial intervals are not lost.

## Test plan
- Reset and run: TICK_DIV=4, En=1, Up=1, from Reset.
  - Digits step 00→01→02 with one step every 4 cycles.
  - First step occurs 4 cycles after Reset deasserts.
- Carry and wrap, counting up: Load 9/8 (98).
  - Next steps give 99, then 00 with Wrap=1 for exactly 1 cycle.
  - The following step gives 01 with Wrap=0.
- Borrow and wrap, counting down: Up=0, Load 1/0 (10).
  - Steps give 09, 08.
  - Load 0/0, then one step gives 99 with Wrap=1.
- Saturating load:
  - D1=12, D0=15 loads 99.
  - D1=10, D0=3 loads 93.
  - Check BCD outputs never exceed 9 over a full 200-step up run.
- Simultaneous events:
  - Load 5/5 on the same cycle S would fire: outputs 55, no step taken, next step exactly 4 cycles later gives 56.
  - Reset asserted together with Load: outputs 00.
- Enable freeze: En=0 for 10 cycles with P=2.
  - Digits and P hold.
  - After En returns to 1, the step occurs 2 cycles later (P=2→3 on the first enabled cycle, step on the second).

Source files
------------

// File: rtl/bcd_counter_2digit_if.sv
// Bus bundle for the two-digit BCD counter:
// control/load inputs and the registered digit outputs.
interface bcd_counter_2digit_if;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d1;
  logic [3:0] d0;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       wrap;

  modport master (
    output en, up, load, d1, d0,
    input  bcd1, bcd0, wrap
  );

  modport slave (
    input  en, up, load, d1, d0,
    output bcd1, bcd0, wrap
  );
endinterface

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter with tick prescaler,
// saturating parallel load and a one-cycle wrap pulse.
module bcd_counter_2digit #(
  parameter int TICK_DIV = 50000000
) (
  input logic clk_i,
  input logic rst_i,
  bcd_counter_2digit_if.slave bus
);

  localparam logic [25:0] PMAX = 26'(TICK_DIV - 1);

  logic [25:0] p_q, p_d;
  logic [3:0]  bcd1_q, bcd1_d;
  logic [3:0]  bcd0_q, bcd0_d;
  logic        wrap_q, wrap_d;
  logic        step;
  logic [3:0]  ld1, ld0;

  assign step = bus.en && (p_q == PMAX);
  assign ld1  = (bus.d1 > 4'd9) ? 4'd9 : bus.d1;
  assign ld0  = (bus.d0 > 4'd9) ? 4'd9 : bus.d0;

  always_comb begin
    p_d    = p_q;
    bcd1_d = bcd1_q;
    bcd0_d = bcd0_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      p_d    = '0;
      bcd1_d = ld1;
      bcd0_d = ld0;
    end else if (step) begin
      p_d = '0;
      if (bus.up) begin
        if (bcd0_q == 4'd9) begin
          bcd0_d = 4'd0;
          if (bcd1_q == 4'd9) begin
            bcd1_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            bcd1_d = bcd1_q + 4'd1;
          end
        end else begin
          bcd0_d = bcd0_q + 4'd1;
        end
      end else begin
        if (bcd0_q == 4'd0) begin
          bcd0_d = 4'd9;
          if (bcd1_q == 4'd0) begin
            bcd1_d = 4'd9;
            wrap_d = 1'b1;
          end else begin
            bcd1_d = bcd1_q - 4'd1;
          end
        end else begin
          bcd0_d = bcd0_q - 4'd1;
        end
      end
    end else if (bus.en) begin
      p_d = p_q + 26'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q    <= '0;
      bcd1_q <= '0;
      bcd0_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      bcd1_q <= bcd1_d;
      bcd0_q <= bcd0_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.bcd1 = bcd1_q;
  assign bus.bcd0 = bcd0_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Directed bench for bcd_counter_2digit with a decimal
// value model checked every cycle plus literal checks.
module tb_bcd_counter_2digit;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;

  bcd_counter_2digit_if bus ();

  bcd_counter_2digit #(.TICK_DIV(TD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: counter as a decimal value 0..99
  int mv = 0;
  int mp = 0;
  int mw = 0;
  bit mvalid = 1'b0;

  function automatic int sat9(input logic [3:0] d);
    return (int'(d) > 9) ? 9 : int'(d);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mv = 0; mp = 0; mw = 0; mvalid = 1'b1;
    end else if (bus.load) begin
      mv = 10 * sat9(bus.d1) + sat9(bus.d0);
      mp = 0; mw = 0;
    end else if (bus.en) begin
      mw = 0;
      if (mp == TD - 1) begin
        mp = 0;
        if (bus.up) begin
          mw = (mv == 99) ? 1 : 0;
          mv = (mv + 1) % 100;
        end else begin
          mw = (mv == 0) ? 1 : 0;
          mv = (mv + 99) % 100;
        end
      end else begin
        mp++;
      end
    end else begin
      mw = 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int val();
    return 10 * int'(bus.bcd1) + int'(bus.bcd0);
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_bcd1", int'(bus.bcd1), mv / 10);
      chk("model_bcd0", int'(bus.bcd0), mv % 10);
      chk("model_wrap", int'(bus.wrap), mw);
      chk("digit_range", int'(bus.bcd1 <= 4'd9 && bus.bcd0 <= 4'd9), 1);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b);
    bus.load = 1'b1; bus.d1 = a; bus.d0 = b;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0;
    bus.d1 = 4'd0; bus.d0 = 4'd0;
    rst = 1'b1;
    tick();
    chk("reset_val", val(), 0);
    chk("reset_wrap", int'(bus.wrap), 0);
    rst = 1'b0; bus.en = 1'b1;
    tick(3);
    chk("pre_first_step", val(), 0);
    tick();
    chk("first_step", val(), 1);
    tick(4);
    chk("second_step", val(), 2);

    do_load(4'd9, 4'd8);
    chk("load_98", val(), 98);
    tick(4);
    chk("up_99", val(), 99);
    tick(4);
    chk("up_wrap_00", val(), 0);
    chk("up_wrap_hi", int'(bus.wrap), 1);
    tick();
    chk("up_wrap_lo", int'(bus.wrap), 0);
    tick(3);
    chk("up_01", val(), 1);
    chk("up_01_wrap", int'(bus.wrap), 0);

    bus.up = 1'b0;
    do_load(4'd1, 4'd0);
    chk("load_10", val(), 10);
    tick(4);
    chk("dn_09", val(), 9);
    tick(4);
    chk("dn_08", val(), 8);
    do_load(4'd0, 4'd0);
    tick(4);
    chk("dn_wrap_99", val(), 99);
    chk("dn_wrap_hi", int'(bus.wrap), 1);
    tick();
    chk("dn_wrap_lo", int'(bus.wrap), 0);

    do_load(4'd12, 4'd15);
    chk("sat_99", val(), 99);
    do_load(4'd10, 4'd3);
    chk("sat_93", val(), 93);

    bus.up = 1'b1;
    tick(3);
    do_load(4'd5, 4'd5);
    chk("load_vs_step", val(), 55);
    tick(3);
    chk("no_early_step", val(), 55);
    tick();
    chk("step_56", val(), 56);

    rst = 1'b1;
    bus.load = 1'b1; bus.d1 = 4'd7; bus.d0 = 4'd7;
    tick();
    chk("rst_over_load", val(), 0);
    rst = 1'b0; bus.load = 1'b0;

    tick(2);
    bus.en = 1'b0;
    tick(10);
    chk("freeze_val", val(), 0);
    bus.en = 1'b1;
    tick();
    chk("resume_p3", val(), 0);
    tick();
    chk("resume_step", val(), 1);

    tick(200 * TD);
    chk("run200", val(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
